// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the 2R1W register file with scoreboard.
package regfile_pkg;

  localparam int unsigned DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// Datapath-side bundle of the register file: write, two reads, reservation and clear control.
interface regfile_2r1w_sb_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              We;
  logic [ADDR_W-1:0] Wa;
  logic [DATA_W-1:0] Wd;
  logic [ADDR_W-1:0] Ra;
  logic [ADDR_W-1:0] Rb;
  logic [DATA_W-1:0] Rx;
  logic [DATA_W-1:0] Ry;
  logic              Rsv_en;
  logic [ADDR_W-1:0] Rsv_addr;
  logic              Hazard_x;
  logic              Hazard_y;
  logic              Clr_req;
  logic              Busy;
  logic              Clr_done;
  logic              Wr_drop;

  modport master (
    output We, Wa, Wd, Ra, Rb, Rsv_en, Rsv_addr, Clr_req,
    input  Rx, Ry, Hazard_x, Hazard_y, Busy, Clr_done, Wr_drop
  );

  modport slave (
    input  We, Wa, Wd, Ra, Rb, Rsv_en, Rsv_addr, Clr_req,
    output Rx, Ry, Hazard_x, Hazard_y, Busy, Clr_done, Wr_drop
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per entry, set by reservation, cleared by the landing write.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W  = 3,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic              i_clr_all,
  input  logic [ADDR_W-1:0] i_ra,
  input  logic [ADDR_W-1:0] i_rb,
  output logic              o_haz_x,
  output logic              o_haz_y
);
  localparam int unsigned Depth = depth_of(ADDR_W);

  logic [Depth-1:0] r_pend;
  logic [Depth-1:0] w_pend_d;

  // Set is applied after clear so a new producer wins over the retiring one.
  always_comb begin
    w_pend_d = r_pend;
    if (i_clr_en) w_pend_d[i_clr_addr] = 1'b0;
    if (i_set_en) w_pend_d[i_set_addr] = 1'b1;
    if (i_clr_all) w_pend_d = '0;
    if (ZERO_R0) w_pend_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_pend <= '0;
    else     r_pend <= w_pend_d;
  end

  assign o_haz_x = r_pend[i_ra] && !(i_clr_en && (i_clr_addr == i_ra));
  assign o_haz_y = r_pend[i_rb] && !(i_clr_en && (i_clr_addr == i_rb));

endmodule

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with write-first bypass, optional zero R0,
// hazard scoreboard and a one-entry-per-cycle soft-clear engine.
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          ZERO_R0 = 1'b0
) (
  input logic               Clk,
  input logic               Rst,
  regfile_2r1w_sb_if.slave  bus
);
  localparam int unsigned Depth = depth_of(ADDR_W);
  localparam int unsigned IdxW  = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [Depth];
  clr_state_t        r_state;
  logic [IdxW-1:0]   r_idx;
  logic              r_clr_done;
  logic              r_wr_drop;

  logic w_busy, w_wr_acc, w_wr_mem, w_clr_start, w_rsv_set;

  assign w_busy      = (r_state == CLEAR);
  assign w_wr_acc    = bus.We && !w_busy;
  assign w_wr_mem    = w_wr_acc && !(ZERO_R0 && (bus.Wa == '0));
  assign w_clr_start = (r_state == IDLE) && bus.Clr_req;
  assign w_rsv_set   = bus.Rsv_en && !w_busy;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_clr_done <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      r_wr_drop  <= bus.We && w_busy;
      unique case (r_state)
        IDLE: begin
          if (bus.Clr_req) begin
            r_state <= CLEAR;
            r_idx   <= '0;
          end
        end
        CLEAR: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == IdxW'(Depth - 1)) begin
            r_state    <= DONE;
            r_clr_done <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_busy) begin
      r_mem[r_idx[ADDR_W-1:0]] <= '0;
    end else if (w_wr_mem) begin
      r_mem[bus.Wa] <= bus.Wd;
    end
  end

  always_comb begin
    bus.Rx = r_mem[bus.Ra];
    if (w_wr_mem && (bus.Wa == bus.Ra)) bus.Rx = bus.Wd;
    if (Rst || w_busy || (ZERO_R0 && (bus.Ra == '0))) bus.Rx = '0;
    bus.Ry = r_mem[bus.Rb];
    if (w_wr_mem && (bus.Wa == bus.Rb)) bus.Ry = bus.Wd;
    if (Rst || w_busy || (ZERO_R0 && (bus.Rb == '0))) bus.Ry = '0;
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_set_en   (w_rsv_set),
    .i_set_addr (bus.Rsv_addr),
    .i_clr_en   (w_wr_acc),
    .i_clr_addr (bus.Wa),
    .i_clr_all  (w_clr_start),
    .i_ra       (bus.Ra),
    .i_rb       (bus.Rb),
    .o_haz_x    (bus.Hazard_x),
    .o_haz_y    (bus.Hazard_y)
  );

  assign bus.Busy     = w_busy;
  assign bus.Clr_done = r_clr_done;
  assign bus.Wr_drop  = r_wr_drop;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Randomised bench for regfile_2r1w_sb: two instances (plain R0 and zero R0) against one model.
module tb_regfile_2r1w_sb;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int N = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  regfile_2r1w_sb_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  regfile_2r1w_sb_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  regfile_2r1w_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b0)) u_dut0 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (if0)
  );
  regfile_2r1w_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b1)) u_dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (if1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_busy = 0;
  int cnt_done = 0;

  // Reference state: contents and pending flags per instance, plus clear progress.
  logic [7:0] m_mem  [2][N];
  bit         m_pend [2][N];
  int         m_clr_left;
  bit         m_done;
  bit         m_drop;

  // Current stimulus, mirrored to both instances.
  logic       s_we, s_rsv, s_clr;
  logic [2:0] s_wa, s_ra, s_rb, s_rsva;
  logic [7:0] s_wd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic rsv,
                        input logic [2:0] rsva, input logic clr);
    s_we = we; s_wa = wa; s_wd = wd; s_ra = ra; s_rb = rb;
    s_rsv = rsv; s_rsva = rsva; s_clr = clr;
    if0.We = we; if0.Wa = wa; if0.Wd = wd; if0.Ra = ra; if0.Rb = rb;
    if0.Rsv_en = rsv; if0.Rsv_addr = rsva; if0.Clr_req = clr;
    if1.We = we; if1.Wa = wa; if1.Wd = wd; if1.Ra = ra; if1.Rb = rb;
    if1.Rsv_en = rsv; if1.Rsv_addr = rsva; if1.Clr_req = clr;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        m_mem[k][i]  = 8'h00;
        m_pend[k][i] = 1'b0;
      end
    m_clr_left = 0;
    m_done = 1'b0;
    m_drop = 1'b0;
  endtask

  function automatic logic [7:0] exp_read(input int k, input logic [2:0] a);
    bit busy = (m_clr_left > 0);
    if (Rst || busy) return 8'h00;
    if (k == 1 && a == 3'd0) return 8'h00;
    if (s_we && s_wa == a) return s_wd;
    return m_mem[k][a];
  endfunction

  function automatic logic exp_haz(input int k, input logic [2:0] a);
    bit busy = (m_clr_left > 0);
    if (Rst || busy) return 1'b0;
    return m_pend[k][a] && !(s_we && s_wa == a);
  endfunction

  task automatic check_dut(input int k, input logic [7:0] rx, input logic [7:0] ry,
                           input logic hx, input logic hy, input logic busy,
                           input logic done, input logic drop);
    bit e_busy = !Rst && (m_clr_left > 0);
    check_eq($sformatf("rx%0d", k), 32'(rx), 32'(exp_read(k, s_ra)));
    check_eq($sformatf("ry%0d", k), 32'(ry), 32'(exp_read(k, s_rb)));
    check_eq($sformatf("hazard_x%0d", k), 32'(hx), 32'(exp_haz(k, s_ra)));
    check_eq($sformatf("hazard_y%0d", k), 32'(hy), 32'(exp_haz(k, s_rb)));
    check_eq($sformatf("busy%0d", k), 32'(busy), 32'(e_busy));
    check_eq($sformatf("clr_done%0d", k), 32'(done), 32'(!Rst && m_done));
    check_eq($sformatf("wr_drop%0d", k), 32'(drop), 32'(!Rst && m_drop));
    if (k == 0) begin
      cnt_busy += int'(busy);
      cnt_done += int'(done);
    end
  endtask

  task automatic model_update();
    bit start;
    if (m_clr_left > 0) begin
      m_drop = s_we;
      m_done = (m_clr_left == 1);
      m_clr_left--;
      if (m_clr_left == 0)
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < N; i++) m_mem[k][i] = 8'h00;
    end else begin
      m_drop = 1'b0;
      start  = s_clr && !m_done;
      m_done = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (s_we && !(k == 1 && s_wa == 3'd0)) m_mem[k][s_wa] = s_wd;
        if (start) begin
          for (int i = 0; i < N; i++) m_pend[k][i] = 1'b0;
        end else begin
          if (s_we) m_pend[k][s_wa] = 1'b0;
          if (s_rsv && !(k == 1 && s_rsva == 3'd0)) m_pend[k][s_rsva] = 1'b1;
        end
      end
      if (start) m_clr_left = N;
    end
  endtask

  // Inputs are applied at the falling edge; outputs are sampled 1 ns later.
  task automatic tick();
    if (Rst) model_reset();
    #1;
    check_dut(0, if0.Rx, if0.Ry, if0.Hazard_x, if0.Hazard_y, if0.Busy, if0.Clr_done, if0.Wr_drop);
    check_dut(1, if1.Rx, if1.Ry, if1.Hazard_x, if1.Hazard_y, if1.Busy, if1.Clr_done, if1.Wr_drop);
    @(posedge Clk);
    if (Rst) model_reset();
    else     model_update();
    @(negedge Clk);
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    set_in(1'b0, 3'd0, 8'h00, ra, rb, 1'b0, 3'd0, 1'b0);
    tick();
  endtask

  initial begin
    model_reset();
    set_in(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    @(negedge Clk);

    // Reset sweep: reads must be zero even with a write presented.
    for (int i = 0; i < N; i++) begin
      set_in(1'b1, 3'(i), 8'($urandom), 3'(i), 3'(7 - i), 1'b1, 3'(i), 1'b0);
      tick();
    end
    Rst = 1'b0;

    // Bypass, then read back from storage.
    set_in(1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 1'b0, 3'd0, 1'b0);
    tick();
    idle(3'd3, 3'd3);

    // Scoreboard: reserve, hazard, resolve, then simultaneous set and clear.
    set_in(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0);
    tick();
    idle(3'd5, 3'd5);
    set_in(1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 1'b0, 3'd0, 1'b0);
    tick();
    idle(3'd5, 3'd2);
    set_in(1'b1, 3'd5, 8'h77, 3'd1, 3'd2, 1'b1, 3'd5, 1'b0);
    tick();
    idle(3'd5, 3'd5);

    // Entry 0: reservation and write (zero-R0 instance must ignore both).
    set_in(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0);
    tick();
    set_in(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    idle(3'd0, 3'd0);

    // Fill 1..8, pulse clear, write during busy, read everything back.
    for (int i = 0; i < N; i++) begin
      set_in(1'b1, 3'(i), 8'(i + 1), 3'(i), 3'(i), 1'b0, 3'd0, 1'b0);
      tick();
    end
    cnt_busy = 0;
    cnt_done = 0;
    set_in(1'b0, 3'd0, 8'h00, 3'd2, 3'd6, 1'b0, 3'd0, 1'b1);
    tick();
    set_in(1'b1, 3'd4, 8'h99, 3'd4, 3'd4, 1'b1, 3'd4, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) idle(3'(i), 3'(7 - i));
    check_eq("busy_len", 32'(cnt_busy), 32'd8);
    check_eq("done_pulses", 32'(cnt_done), 32'd1);
    for (int i = 0; i < N; i++) idle(3'(i), 3'(i));

    // Level-held request: ignored in DONE, accepted again from IDLE.
    for (int i = 0; i < 22; i++) begin
      set_in(1'(i % 3 == 0), 3'(i), 8'($urandom), 3'(i), 3'(i + 1), 1'b1, 3'(i), 1'b1);
      tick();
    end

    // Reset during the clear: no completion pulse afterwards.
    idle(3'd0, 3'd0);
    set_in(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) idle(3'd1, 3'd2);
    cnt_done = 0;
    Rst = 1'b1;
    idle(3'd3, 3'd4);
    Rst = 1'b0;
    for (int i = 0; i < 12; i++) idle(3'(i), 3'(i + 3));
    check_eq("no_done_after_rst", 32'(cnt_done), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom),
             3'($urandom_range(7)), 3'($urandom_range(7)),
             1'($urandom_range(9) < 3), 3'($urandom_range(7)),
             1'($urandom_range(29) == 0));
      Rst = ($urandom_range(149) == 0);
      tick();
    end
    Rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
